// File: rtl/clz_restore_if.sv
// Operand/result handshake bundle for clz_restore.
// The source side drives in_*, the sink side drives out_ready.
interface clz_restore_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_count;
   logic        in_zero;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   modport master (
      output in_valid, in_data, in_count, in_zero, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_count, in_zero, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/clz_restore.sv
// Iterative inverse of a leading-zero count: shifts a normalized word right by
// the latched count in five binary steps (16/8/4/2/1), one step per clock.
module clz_restore (
   input  logic          clk,
   input  logic          resetn,
   clz_restore_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [2:0]  step_r;
   logic [2:0]  step_s;
   logic [31:0] word_r;
   logic [31:0] word_s;
   logic [4:0]  count_r;
   logic [4:0]  count_s;
   logic        zero_r;
   logic        zero_s;
   logic        out_valid_r;
   logic        out_valid_s;
   logic [31:0] out_data_r;
   logic [31:0] out_data_s;

   // One binary stage: shift right by 2^st when en is set, zero-filling from the top.
   function automatic logic [31:0] shift_stage(input logic [31:0] w,
                                               input logic        en,
                                               input logic [2:0]  st);
      logic [4:0] amt;
      amt = 5'd1 << st;
      if (en) begin
         shift_stage = w >> amt;
      end else begin
         shift_stage = w;
      end
   endfunction

   // State and datapath registers; reset clears every latched operand.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r     <= IDLE;
         step_r      <= 3'd0;
         word_r      <= 32'h0;
         count_r     <= 5'd0;
         zero_r      <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= 32'h0;
      end else begin
         state_r     <= state_s;
         step_r      <= step_s;
         word_r      <= word_s;
         count_r     <= count_s;
         zero_r      <= zero_s;
         out_valid_r <= out_valid_s;
         out_data_r  <= out_data_s;
      end
   end

   // Next-state and next-datapath logic.
   always_comb begin
      state_s     = state_r;
      step_s      = step_r;
      word_s      = word_r;
      count_s     = count_r;
      zero_s      = zero_r;
      out_valid_s = out_valid_r;
      out_data_s  = out_data_r;
      case (state_r)
         IDLE: begin
            // in_ready is high in IDLE, so in_valid alone is an accept.
            if (bus.in_valid) begin
               state_s = SHIFT;
               word_s  = bus.in_data;
               count_s = bus.in_count;
               zero_s  = bus.in_zero;
               step_s  = 3'd4;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            word_s = shift_stage(word_r, count_r[step_r], step_r);
            if (step_r == 3'd0) begin
               state_s     = DONE;
               out_valid_s = 1'b1;
               out_data_s  = zero_r ? 32'h0 : word_s;
            end else begin
               step_s = step_r - 3'd1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_s     = IDLE;
               out_valid_s = 1'b0;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s     = IDLE;
            out_valid_s = 1'b0;
            step_s      = 3'd0;
         end
      endcase
   end

   assign bus.in_ready  = (state_r == IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_clz_restore.sv
// Self-checking bench for clz_restore: directed vector table, stall/reset
// sequences and a random sweep, all checked through an in-order scoreboard.
module tb_clz_restore;

   logic clk;
   logic resetn;
   clz_restore_if bus();

   clz_restore dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  count;
      logic        zero;
      logic [31:0] exp;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;
   vec_t        vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // In-order scoreboard: compare each consumed result against the oldest expectation.
   always @(negedge clk) begin
      if (resetn && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %h with empty scoreboard at %0t", bus.out_data, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("scoreboard", bus.out_data, mon_exp);
         end
      end
   end

   // Call at posedge+1; returns at posedge+1 just after the accept edge.
   task automatic send(input logic [31:0] d, input logic [4:0] c, input logic z);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_count = c;
      bus.in_zero  = z;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         exp_q.push_back(z ? 32'h0 : (d >> c));
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready never rose for data %h at %0t", d, $time);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      bus.in_count = 5'($urandom_range(0, 31));
      bus.in_zero  = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_out(output int n);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic run_directed(input logic [31:0] d, input logic [4:0] c, input logic z,
                               input logic [31:0] e);
      int n;
      bus.out_ready = 1'b0;
      send(d, c, z);
      wait_out(n);
      chk("latency", 32'(n), 32'd5);
      chk("out_data", bus.out_data, e);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("out_valid_cleared", {31'd0, bus.out_valid}, 32'd0);
      chk("in_ready_after", {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      int          n;
      bit          stable;
      bit          seen;
      logic [31:0] held;
      bit          sweep_done;

      vecs[0] = '{32'h80000000, 5'd31, 1'b0, 32'h00000001};
      vecs[1] = '{32'hF0000000, 5'd4,  1'b0, 32'h0F000000};
      vecs[2] = '{32'hF0000000, 5'd0,  1'b0, 32'hF0000000};
      vecs[3] = '{32'hFFFFFFFF, 5'd7,  1'b1, 32'h00000000};
      vecs[4] = '{32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001};
      vecs[5] = '{32'h12345678, 5'd16, 1'b0, 32'h00001234};
      vecs[6] = '{32'hDEADBEEF, 5'd8,  1'b0, 32'h00DEADBE};
      vecs[7] = '{32'h80000000, 5'd1,  1'b0, 32'h40000000};
      vecs[8] = '{32'hABCDEF01, 5'd21, 1'b0, 32'h0000055E};
      vecs[9] = '{32'h80000000, 5'd0,  1'b1, 32'h00000000};

      resetn        = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'h0;
      bus.in_count  = 5'd0;
      bus.in_zero   = 1'b0;
      bus.out_ready = 1'b0;

      #3;
      chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset_out_data", bus.out_data, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      #1;
      chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         run_directed(vecs[i].data, vecs[i].count, vecs[i].zero, vecs[i].exp);
      end

      // Long output stall with a competing in_valid that must be ignored.
      send(32'hA5A5A5A5, 5'd3, 1'b0);
      wait_out(n);
      chk("stall_latency", 32'(n), 32'd5);
      held   = bus.out_data;
      chk("stall_data", held, 32'h14B4B4B4);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h11111111;
      bus.in_count = 5'd0;
      bus.in_zero  = 1'b0;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_data !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
            stable = 1'b0;
      end
      chk("stall_stable", {31'd0, stable}, 32'd1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("stall_release_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("stall_release_ready", {31'd0, bus.in_ready}, 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("stall_no_second", {31'd0, seen}, 32'd0);

      // Reset during SHIFT aborts the operand.
      send(32'h80000000, 5'd2, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("abort_out_data", bus.out_data, 32'h0);
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      #1;
      chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.out_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("abort_no_stale", {31'd0, seen}, 32'd0);
      run_directed(32'hC0000000, 5'd1, 1'b0, 32'h60000000);

      // Random sweep with random sink stalls.
      sweep_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 3000; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               send($urandom, 5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
            end
            sweep_done = 1'b1;
         end
         begin
            while (!sweep_done) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      bus.out_ready = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      chk("sweep_drain", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
